// File: rtl/mem_access_unit.sv
// Memory-stage access controller: one data-memory transaction per instruction on a
// ready-based bus, with store lane steering, load extension, alignment check and timeout.
module mem_access_unit #(
    parameter int unsigned MAX_WAIT  = 255,
    parameter logic [2:0]  WDSEL_MEM = 3'b001
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic [31:0] alures_in,
    input  logic [31:0] rs2_data_in,
    input  logic [1:0]  MemWrite_in,
    input  logic [2:0]  DMType_in,
    input  logic [2:0]  WDSel_in,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,
    output logic        mem_stall,
    output logic [31:0] load_data,
    output logic        load_valid,
    output logic        misalign_exc,
    output logic        bus_err
);

    localparam int unsigned CNT_W = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_WAIT - 1);

    localparam logic [2:0] DM_WORD = 3'b000;
    localparam logic [2:0] DM_HALF = 3'b001;
    localparam logic [2:0] DM_HALFU = 3'b010;
    localparam logic [2:0] DM_BYTE = 3'b011;
    localparam logic [2:0] DM_BYTEU = 3'b100;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CNT_W-1:0]   r_wait_cnt;
    logic               r_killed;
    logic               r_is_load;
    logic [1:0]         r_off;
    logic [2:0]         r_dmtype;
    logic               r_mem_req;
    logic               r_mem_we;
    logic [31:0]        r_mem_addr;
    logic [31:0]        r_mem_wdata;
    logic [3:0]         r_mem_wstrb;
    logic [31:0]        r_load_data;
    logic               r_load_valid;
    logic               r_misalign;
    logic               r_bus_err;

    logic               w_is_store;
    logic               w_is_load;
    logic               w_access;
    logic               w_half;
    logic               w_byte;
    logic               w_word;
    logic               w_misalign;
    logic               w_start;
    logic               w_timeout;
    logic [31:0]        w_wdata;
    logic [3:0]         w_wstrb;
    logic [15:0]        w_lane;
    logic [31:0]        w_load_ext;

    // Access decode; a simultaneous store and load indication is a store.
    assign w_is_store = |MemWrite_in;
    assign w_is_load  = (WDSel_in == WDSEL_MEM);
    assign w_access   = (w_is_store || w_is_load) && !flush;
    assign w_half     = (DMType_in == DM_HALF) || (DMType_in == DM_HALFU);
    assign w_byte     = (DMType_in == DM_BYTE) || (DMType_in == DM_BYTEU);
    assign w_word     = !w_half && !w_byte;
    assign w_misalign = (w_word && (alures_in[1:0] != 2'b00)) || (w_half && alures_in[0]);
    assign w_start    = (r_state == S_IDLE) && w_access && !w_misalign;
    assign w_timeout  = (r_wait_cnt == CNT_LAST) && !mem_ready;

    // Store lane steering.
    always_comb begin
        w_wdata = rs2_data_in;
        w_wstrb = 4'b1111;
        if (w_half) begin
            w_wdata = {2{rs2_data_in[15:0]}};
            w_wstrb = 4'b0011 << alures_in[1:0];
        end else if (w_byte) begin
            w_wdata = {4{rs2_data_in[7:0]}};
            w_wstrb = 4'b0001 << alures_in[1:0];
        end
    end

    // Load extraction from the captured byte offset.
    assign w_lane = 16'(mem_rdata >> {r_off, 3'b000});

    always_comb begin
        w_load_ext = mem_rdata;
        case (r_dmtype)
            DM_HALF:  w_load_ext = {{16{w_lane[15]}}, w_lane};
            DM_HALFU: w_load_ext = {16'h0000, w_lane};
            DM_BYTE:  w_load_ext = {{24{w_lane[7]}}, w_lane[7:0]};
            DM_BYTEU: w_load_ext = {24'h000000, w_lane[7:0]};
            default:  w_load_ext = mem_rdata;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_start) w_state_nxt = S_BUSY;
            S_BUSY:  if (mem_ready || w_timeout) w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Capture, wait counting and completion bookkeeping.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wait_cnt   <= '0;
            r_killed     <= 1'b0;
            r_is_load    <= 1'b0;
            r_off        <= 2'b00;
            r_dmtype     <= 3'b000;
            r_mem_req    <= 1'b0;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= 32'h0;
            r_mem_wdata  <= 32'h0;
            r_mem_wstrb  <= 4'b0000;
            r_load_data  <= 32'h0;
            r_load_valid <= 1'b0;
            r_misalign   <= 1'b0;
            r_bus_err    <= 1'b0;
        end else begin
            r_mem_req    <= (w_state_nxt == S_BUSY);
            r_load_valid <= 1'b0;
            r_bus_err    <= 1'b0;
            r_misalign   <= (r_state == S_IDLE) && w_access && w_misalign;
            case (r_state)
                S_IDLE: begin
                    r_killed <= 1'b0;
                    if (w_start) begin
                        r_mem_addr  <= {alures_in[31:2], 2'b00};
                        r_off       <= alures_in[1:0];
                        r_dmtype    <= DMType_in;
                        r_mem_we    <= w_is_store;
                        r_is_load   <= !w_is_store;
                        r_mem_wdata <= w_wdata;
                        r_mem_wstrb <= w_is_store ? w_wstrb : 4'b0000;
                        r_wait_cnt  <= '0;
                    end
                end
                S_BUSY: begin
                    if (flush) r_killed <= 1'b1;
                    if (mem_ready) begin
                        if (r_is_load && !r_killed && !flush) begin
                            r_load_data  <= w_load_ext;
                            r_load_valid <= 1'b1;
                        end
                    end else if (w_timeout) begin
                        r_bus_err <= 1'b1;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + CNT_W'(1);
                    end
                end
                S_DONE: r_killed <= 1'b0;
                default: r_killed <= 1'b0;
            endcase
        end
    end

    // Stall is combinational so the pipeline holds in the same cycle the access appears.
    assign mem_stall = rst && (w_start || (r_state == S_BUSY));

    assign mem_req      = r_mem_req;
    assign mem_we       = r_mem_we;
    assign mem_addr     = r_mem_addr;
    assign mem_wdata    = r_mem_wdata;
    assign mem_wstrb    = r_mem_wstrb;
    assign load_data    = r_load_data;
    assign load_valid   = r_load_valid;
    assign misalign_exc = r_misalign;
    assign bus_err      = r_bus_err;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed table-driven bench for mem_access_unit with MAX_WAIT=4 and a small bus responder.
module tb_mem_access_unit;

    logic        clk;
    logic        rst;
    logic        flush;
    logic [31:0] alures_in;
    logic [31:0] rs2_data_in;
    logic [1:0]  MemWrite_in;
    logic [2:0]  DMType_in;
    logic [2:0]  WDSel_in;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic        mem_stall;
    logic [31:0] load_data;
    logic        load_valid;
    logic        misalign_exc;
    logic        bus_err;

    mem_access_unit #(.MAX_WAIT(4), .WDSEL_MEM(3'b001)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .alures_in(alures_in), .rs2_data_in(rs2_data_in),
        .MemWrite_in(MemWrite_in), .DMType_in(DMType_in), .WDSel_in(WDSel_in),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata),
        .mem_stall(mem_stall), .load_data(load_data), .load_valid(load_valid),
        .misalign_exc(misalign_exc), .bus_err(bus_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] name;
        logic [31:0] addr;
        logic [31:0] rs2;
        logic [31:0] rdata;
        logic [1:0]  mw;
        logic [2:0]  dm;
        logic [2:0]  wd;
        int          waits;
        int          flush_at;
        logic        flush_idle;
        int          e_stall;
        int          e_req;
        logic        e_we;
        logic [31:0] e_addr;
        logic [31:0] e_wdata;
        logic [3:0]  e_wstrb;
        int          e_lv;
        logic [31:0] e_ld;
        int          e_mis;
        int          e_err;
    } vec_t;

    int checks = 0;
    int failures = 0;

    int          o_stall, o_req, o_lv, o_mis, o_err, o_stab;
    logic        o_we, o_done;
    logic [31:0] o_addr, o_wdata;
    logic [3:0]  o_wstrb;

    vec_t vt[19];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [63:0] name, input logic [31:0] addr,
                                input logic [31:0] rs2, input logic [31:0] rdata,
                                input logic [1:0] mw, input logic [2:0] dm, input logic [2:0] wd,
                                input int waits, input int flush_at, input logic flush_idle,
                                input int e_stall, input int e_req, input logic e_we,
                                input logic [31:0] e_addr, input logic [31:0] e_wdata,
                                input logic [3:0] e_wstrb, input int e_lv,
                                input logic [31:0] e_ld, input int e_mis, input int e_err);
        vec_t v;
        v.name = name; v.addr = addr; v.rs2 = rs2; v.rdata = rdata;
        v.mw = mw; v.dm = dm; v.wd = wd; v.waits = waits;
        v.flush_at = flush_at; v.flush_idle = flush_idle;
        v.e_stall = e_stall; v.e_req = e_req; v.e_we = e_we; v.e_addr = e_addr;
        v.e_wdata = e_wdata; v.e_wstrb = e_wstrb; v.e_lv = e_lv; v.e_ld = e_ld;
        v.e_mis = e_mis; v.e_err = e_err;
        return v;
    endfunction

    task automatic clear_inputs();
        flush = 1'b0; alures_in = 32'h0; rs2_data_in = 32'h0;
        MemWrite_in = 2'b00; DMType_in = 3'b000; WDSel_in = 3'b000;
        mem_ready = 1'b0; mem_rdata = 32'h0;
    endtask

    // Presents one instruction until the stage releases, acting as the bus, then idles two cycles.
    task automatic run_vec(input vec_t v);
        int busy;
        logic s;
        o_stall = 0; o_req = 0; o_lv = 0; o_mis = 0; o_err = 0; o_stab = 0;
        o_we = 1'b0; o_addr = 32'h0; o_wdata = 32'h0; o_wstrb = 4'h0; o_done = 1'b0;
        busy = 0;
        alures_in = v.addr; rs2_data_in = v.rs2; MemWrite_in = v.mw;
        DMType_in = v.dm; WDSel_in = v.wd; flush = v.flush_idle;
        mem_ready = 1'b0; mem_rdata = v.rdata;
        for (int c = 0; c < 40 && !o_done; c++) begin
            @(negedge clk);
            s = mem_stall;
            if (s) o_stall++;
            if (load_valid) o_lv++;
            if (misalign_exc) o_mis++;
            if (bus_err) o_err++;
            if (mem_req) begin
                if (o_req == 0) begin
                    o_we = mem_we; o_addr = mem_addr; o_wdata = mem_wdata; o_wstrb = mem_wstrb;
                end else if (mem_we !== o_we || mem_addr !== o_addr ||
                             mem_wdata !== o_wdata || mem_wstrb !== o_wstrb) begin
                    o_stab++;
                end
                o_req++;
                mem_ready = (busy == v.waits);
                flush = (busy == v.flush_at);
                busy++;
            end else begin
                mem_ready = 1'b0;
                flush = v.flush_idle;
            end
            if (!s) o_done = 1'b1;
            @(posedge clk);
            #1;
        end
        clear_inputs();
        repeat (2) begin
            @(negedge clk);
            if (mem_stall) o_stall++;
            if (mem_req) o_req++;
            if (load_valid) o_lv++;
            if (misalign_exc) o_mis++;
            if (bus_err) o_err++;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //            name       addr          rs2           rdata         mw     dm      wd     wt  fa fi  st rq we  e_addr        e_wdata       wstrb  lv  e_ld          mi er
        vt[0]  = mk("SW",      32'h100, 32'hDEADBEEF, 32'h0,        2'b01, 3'b000, 3'b000, 0, -1, 0, 2, 1, 1, 32'h100, 32'hDEADBEEF, 4'hF, 0, 32'h0,        0, 0);
        vt[1]  = mk("SB",      32'h103, 32'h000000A5, 32'h0,        2'b01, 3'b011, 3'b000, 0, -1, 0, 2, 1, 1, 32'h100, 32'hA5A5A5A5, 4'h8, 0, 32'h0,        0, 0);
        vt[2]  = mk("SH",      32'h102, 32'h1234BEEF, 32'h0,        2'b01, 3'b001, 3'b000, 0, -1, 0, 2, 1, 1, 32'h100, 32'hBEEFBEEF, 4'hC, 0, 32'h0,        0, 0);
        vt[3]  = mk("LH",      32'h102, 32'h0,        32'h80017FFF, 2'b00, 3'b001, 3'b001, 0, -1, 0, 2, 1, 0, 32'h100, 32'h0,        4'h0, 1, 32'hFFFF8001, 0, 0);
        vt[4]  = mk("LHU",     32'h102, 32'h0,        32'h80017FFF, 2'b00, 3'b010, 3'b001, 0, -1, 0, 2, 1, 0, 32'h100, 32'h0,        4'h0, 1, 32'h00008001, 0, 0);
        vt[5]  = mk("LB",      32'h101, 32'h0,        32'h12348056, 2'b00, 3'b011, 3'b001, 0, -1, 0, 2, 1, 0, 32'h100, 32'h0,        4'h0, 1, 32'hFFFFFF80, 0, 0);
        vt[6]  = mk("LBU",     32'h103, 32'h0,        32'hC3000000, 2'b00, 3'b100, 3'b001, 0, -1, 0, 2, 1, 0, 32'h100, 32'h0,        4'h0, 1, 32'h000000C3, 0, 0);
        vt[7]  = mk("LWwait3", 32'h200, 32'h0,        32'hCAFEF00D, 2'b00, 3'b000, 3'b001, 3, -1, 0, 5, 4, 0, 32'h200, 32'h0,        4'h0, 1, 32'hCAFEF00D, 0, 0);
        vt[8]  = mk("LWmis",   32'h101, 32'h0,        32'h11111111, 2'b00, 3'b000, 3'b001, 0, -1, 0, 0, 0, 0, 32'h0,   32'h0,        4'h0, 0, 32'hCAFEF00D, 1, 0);
        vt[9]  = mk("SHmis",   32'h103, 32'h5555,     32'h0,        2'b01, 3'b001, 3'b000, 0, -1, 0, 0, 0, 0, 32'h0,   32'h0,        4'h0, 0, 32'hCAFEF00D, 1, 0);
        vt[10] = mk("SWmis",   32'h102, 32'h6666,     32'h0,        2'b10, 3'b000, 3'b000, 0, -1, 0, 0, 0, 0, 32'h0,   32'h0,        4'h0, 0, 32'hCAFEF00D, 1, 0);
        vt[11] = mk("SWLW",    32'h300, 32'h11223344, 32'hFFFFFFFF, 2'b01, 3'b000, 3'b001, 0, -1, 0, 2, 1, 1, 32'h300, 32'h11223344, 4'hF, 0, 32'hCAFEF00D, 0, 0);
        vt[12] = mk("LWtmo",   32'h400, 32'h0,        32'h0,        2'b00, 3'b000, 3'b001, 100, -1, 0, 5, 4, 0, 32'h400, 32'h0,     4'h0, 0, 32'hCAFEF00D, 0, 1);
        vt[13] = mk("LWflI",   32'h500, 32'h0,        32'h0,        2'b00, 3'b000, 3'b001, 0, -1, 1, 0, 0, 0, 32'h0,   32'h0,        4'h0, 0, 32'hCAFEF00D, 0, 0);
        vt[14] = mk("LBflB",   32'h104, 32'h0,        32'h000000FF, 2'b00, 3'b011, 3'b001, 0, 0, 0, 2, 1, 0, 32'h104, 32'h0,        4'h0, 0, 32'hCAFEF00D, 0, 0);
        vt[15] = mk("SBflB",   32'h002, 32'h0000007E, 32'h0,        2'b01, 3'b011, 3'b000, 0, 0, 0, 2, 1, 1, 32'h000, 32'h7E7E7E7E, 4'h4, 0, 32'hCAFEF00D, 0, 0);
        vt[16] = mk("SWflTmo", 32'h010, 32'h00000001, 32'h0,        2'b01, 3'b000, 3'b000, 100, 1, 0, 5, 4, 1, 32'h010, 32'h00000001, 4'hF, 0, 32'hCAFEF00D, 0, 1);
        vt[17] = mk("LHpost",  32'h100, 32'h0,        32'h0000FFFE, 2'b00, 3'b001, 3'b001, 0, -1, 0, 2, 1, 0, 32'h100, 32'h0,        4'h0, 1, 32'hFFFFFFFE, 0, 0);
        vt[18] = mk("LWrst",   32'h700, 32'h0,        32'h13579BDF, 2'b00, 3'b000, 3'b001, 0, -1, 0, 2, 1, 0, 32'h700, 32'h0,        4'h0, 1, 32'h13579BDF, 0, 0);

        rst = 1'b0;
        clear_inputs();
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_req", {31'h0, mem_req}, 32'h0);
        chk("reset_we", {31'h0, mem_we}, 32'h0);
        chk("reset_stall", {31'h0, mem_stall}, 32'h0);
        chk("reset_addr", mem_addr, 32'h0);
        chk("reset_wdata", mem_wdata, 32'h0);
        chk("reset_wstrb", {28'h0, mem_wstrb}, 32'h0);
        chk("reset_ld", load_data, 32'h0);
        chk("reset_pulses", {29'h0, load_valid, misalign_exc, bus_err}, 32'h0);
        @(posedge clk);
        #1 rst = 1'b1;

        for (int i = 0; i < 18; i++) begin
            run_vec(vt[i]);
            chk($sformatf("%s_bound", vt[i].name), {31'h0, o_done}, 32'h1);
            chk($sformatf("%s_stall", vt[i].name), 32'(o_stall), 32'(vt[i].e_stall));
            chk($sformatf("%s_req", vt[i].name), 32'(o_req), 32'(vt[i].e_req));
            if (vt[i].e_req > 0) begin
                chk($sformatf("%s_we", vt[i].name), {31'h0, o_we}, {31'h0, vt[i].e_we});
                chk($sformatf("%s_addr", vt[i].name), o_addr, vt[i].e_addr);
                chk($sformatf("%s_wstrb", vt[i].name), {28'h0, o_wstrb}, {28'h0, vt[i].e_wstrb});
                chk($sformatf("%s_stable", vt[i].name), 32'(o_stab), 32'h0);
                if (vt[i].mw != 2'b00)
                    chk($sformatf("%s_wdata", vt[i].name), o_wdata, vt[i].e_wdata);
            end
            chk($sformatf("%s_lv", vt[i].name), 32'(o_lv), 32'(vt[i].e_lv));
            chk($sformatf("%s_ld", vt[i].name), load_data, vt[i].e_ld);
            chk($sformatf("%s_mis", vt[i].name), 32'(o_mis), 32'(vt[i].e_mis));
            chk($sformatf("%s_err", vt[i].name), 32'(o_err), 32'(vt[i].e_err));
        end

        // Reset asserted while a load is outstanding.
        alures_in = 32'h600; WDSel_in = 3'b001; DMType_in = 3'b000; MemWrite_in = 2'b00;
        mem_ready = 1'b0;
        @(posedge clk);
        #1;
        chk("rstbusy_req_before", {31'h0, mem_req}, 32'h1);
        rst = 1'b0;
        #1;
        chk("rstbusy_req", {31'h0, mem_req}, 32'h0);
        chk("rstbusy_stall", {31'h0, mem_stall}, 32'h0);
        chk("rstbusy_we", {31'h0, mem_we}, 32'h0);
        chk("rstbusy_addr", mem_addr, 32'h0);
        chk("rstbusy_wdata", mem_wdata, 32'h0);
        chk("rstbusy_wstrb", {28'h0, mem_wstrb}, 32'h0);
        chk("rstbusy_ld", load_data, 32'h0);
        chk("rstbusy_pulses", {29'h0, load_valid, misalign_exc, bus_err}, 32'h0);
        clear_inputs();
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1;

        run_vec(vt[18]);
        chk("LWrst_bound", {31'h0, o_done}, 32'h1);
        chk("LWrst_stall", 32'(o_stall), 32'(vt[18].e_stall));
        chk("LWrst_req", 32'(o_req), 32'(vt[18].e_req));
        chk("LWrst_addr", o_addr, vt[18].e_addr);
        chk("LWrst_lv", 32'(o_lv), 32'(vt[18].e_lv));
        chk("LWrst_ld", load_data, vt[18].e_ld);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Memory-stage access controller for the pipelined core. It takes the control and data fields of the EX/MEM register and runs one data-memory transaction per instruction on a ready-based bus. It does store byte-lane steering, load sign/zero extension, alignment checking and a wait timeout. While a transaction is outstanding it drives `mem_stall` back to the pipeline registers, and it hands the extended load result to the MEM/WB register.

## Interface
Parameters:
- `MAX_WAIT`, default 255: BUSY cycles without `mem_ready` before the access is aborted with `bus_err`.
- `WDSEL_MEM`, default 3'b001: `WDSel_in` encoding that marks a load.

Ports:
- `clk` in 1: clock.
- `rst` in 1: reset, asynchronous, active-low.
- `flush` in 1: kill the current MEM-stage instruction.
- `alures_in` in 32: effective address.
- `rs2_data_in` in 32: store data, already forwarded.
- `MemWrite_in` in 2: nonzero means store.
- `DMType_in` in 3: access size. 000 word, 001 half, 010 half-unsigned, 011 byte, 100 byte-unsigned.
- `WDSel_in` in 3: equal to `WDSEL_MEM` means load.
- `mem_req` out 1: bus request, high only in BUSY.
- `mem_we` out 1: write enable.
- `mem_addr` out 32: word address, with `[1:0]` = 00.
- `mem_wdata` out 32: lane-replicated store data.
- `mem_wstrb` out 4: byte strobes, 0000 for loads.
- `mem_ready` in 1: bus completes the access this cycle.
- `mem_rdata` in 32: read word, valid when `mem_ready`=1.
- `mem_stall` out 1: hold PC, IF/ID, ID/EX and EX/MEM.
- `load_data` out 32: extended load result.
- `load_valid` out 1: one-cycle pulse, `load_data` is updated.
- `misalign_exc` out 1: one-cycle pulse on a misaligned access.
- `bus_err` out 1: one-cycle pulse on a timeout.

## Operation
- An access is present when (`MemWrite_in`≠0 or `WDSel_in`=`WDSEL_MEM`) and `flush`=0. If both store and load are indicated, the access is treated as a store.
- Misaligned means a word access with `addr[1:0]`≠0, or a half access with `addr[0]`=1. A misaligned access:
  - issues no bus request;
  - causes no stall;
  - pulses `misalign_exc` in the following cycle;
  - leaves `load_data` unchanged.
- The FSM has three states: IDLE, BUSY and DONE.
  - IDLE, aligned access present: capture address, size, store/load, `wdata` and `wstrb` into registers, clear `wait_cnt`, go to BUSY.
  - BUSY: `mem_req`=1 with the captured fields. If `mem_ready`=1, go to DONE; for a load, register the extended `mem_rdata` into `load_data`. If `wait_cnt`=`MAX_WAIT`-1 and `mem_ready`=0, go to DONE with an error flag. Otherwise increment `wait_cnt`.
  - DONE: go to IDLE unconditionally. Pulse `load_valid` for a completed load that was not killed. Pulse `bus_err` if the error flag is set.
- Store steering:
  - Word: `wdata` = rs2, `wstrb` = 1111.
  - Half: `wdata` = {2{rs2[15:0]}}, `wstrb` = 0011<<`addr[1:0]`.
  - Byte: `wdata` = {4{rs2[7:0]}}, `wstrb` = 0001<<`addr[1:0]`.
- Load extraction: let `lane` = `mem_rdata`>>(8·`addr[1:0]`). Take `[7:0]` or `[15:0]` of `lane`. Sign-extend for 001 and 011, zero-extend for 010 and 100. Word loads pass through unchanged.
- `mem_stall` is combinational: (IDLE and aligned access present) or BUSY.
- Flush:
  - In IDLE, flush suppresses the access.
  - In BUSY, flush sets a `killed` bit. The bus transaction still completes, so a store is still written. `load_valid` and `load_data` update are suppressed in DONE, and `bus_err` is still reported.
  - `killed` clears on entry to IDLE.
- Reset mid-operation returns the FSM to IDLE immediately and drops `mem_req` with no completion.

## Timing
- Reset values:
  - FSM = IDLE, `wait_cnt`=0, `killed`=0.
  - `mem_req`, `mem_we`, `mem_stall` = 0.
  - `mem_addr`, `mem_wdata`, `load_data` = 0.
  - `mem_wstrb` = 0000.
  - `load_valid`, `misalign_exc`, `bus_err` = 0.
- Access latency with zero-wait memory, where the access is presented in cycle 0:
  - cycle 0: IDLE, stall=1;
  - cycle 1: BUSY, `mem_req`=1, `mem_ready`=1;
  - cycle 2: DONE, stall=0, `load_valid`=1;
  - the pipeline advances at the end of cycle 2.
- Each wait cycle adds one cycle.
- A new access is accepted in the cycle after DONE. There is no re-issue, because the pipeline advanced at DONE.
- `mem_ready` outside BUSY is ignored.
- Timeout: DONE is entered after exactly `MAX_WAIT` BUSY cycles.
- `mem_addr`, `mem_we`, `mem_wdata` and `mem_wstrb` are stable throughout BUSY. They hold their last values otherwise.

## Test plan
- Reset, then `SW`:
  - stimulus: addr 0x100, rs2 0xDEADBEEF, zero-wait memory;
  - response: one cycle with `mem_req`=1, `mem_we`=1, `mem_addr`=0x100, `wstrb`=1111; `mem_stall` high exactly 2 cycles.
- `SB`:
  - stimulus: addr 0x103, rs2 0x000000A5;
  - response: `wdata`=0xA5A5A5A5, `wstrb`=1000.
- `LH` and `LHU`:
  - stimulus: addr 0x102, `mem_rdata`=0x8001_7FFF;
  - response: `LH` gives `load_data`=0xFFFF8001, `LHU` gives 0x00008001; `load_valid` pulses once each.
- `LW` with 3 wait cycles:
  - stimulus: `LW`, memory deasserts `mem_ready` for 3 BUSY cycles;
  - response: stall lasts 5 cycles; `load_data`=`mem_rdata` at DONE.
- `LW` misaligned:
  - stimulus: addr 0x101;
  - response: no `mem_req`, no stall, `misalign_exc` pulses once.
- Flush and timeout:
  - flush asserted in the first BUSY cycle of an `LB`: transaction completes, `load_valid` stays 0, `load_data` unchanged;
  - `MAX_WAIT`=4 with `mem_ready` never asserted: `bus_err` pulses after 4 BUSY cycles, `mem_req` drops;
  - rst asserted during BUSY: all outputs return to reset values at once.
